// File: rtl/turn_manager.sv
// turn_manager
// Two-player turn sequencer for the cat-vs-dog throwing game. It sits between
// the player input/throw logic and the projectile engine. Turns alternate
// CAT -> DOG -> CAT. Each turn runs AIM -> FLIGHT -> SETTLE and then hands
// over to the opponent's AIM.
//
// Ports
//   clk60MHz       in   1  system clock (60 MHz)
//   rst            in   1  synchronous reset, active-high
//   throw_flag     in   1  throw request from the active player (level)
//   in_throw_flag  in   1  high while the projectile is in flight
//   turn           out  3  registered phase code:
//                          0 CAT_AIM, 1 CAT_FLIGHT, 2 DOG_AIM, 3 DOG_FLIGHT,
//                          4 SETTLE_TO_DOG, 5 SETTLE_TO_CAT
//
// Parameters
//   SETTLE_CYCLES   cycles spent in SETTLE (0 = go straight to opponent AIM)
//   FLIGHT_TIMEOUT  max FLIGHT cycles before a forced end (0 = disabled)
//   AIM_TIMEOUT     AIM cycles before the turn is forfeited (TURN_TIMEOUT_EN only)
//
// Build option
//   TURN_TIMEOUT_EN  when defined, an idle AIM phase passes the turn after
//                    AIM_TIMEOUT cycles. When undefined, AIM waits forever and
//                    no AIM counter is built.

module turn_manager #(
  parameter int SETTLE_CYCLES  = 2,
  parameter int FLIGHT_TIMEOUT = 1000000,
  parameter int AIM_TIMEOUT    = 6000000
) (
  input  logic       clk60MHz,
  input  logic       rst,
  input  logic       throw_flag,
  input  logic       in_throw_flag,
  output logic [2:0] turn
);

  typedef enum logic [2:0] {
    CAT_AIM       = 3'd0,
    CAT_FLIGHT    = 3'd1,
    DOG_AIM       = 3'd2,
    DOG_FLIGHT    = 3'd3,
    SETTLE_TO_DOG = 3'd4,
    SETTLE_TO_CAT = 3'd5
  } state_t;

  // Counter widths are clamped to at least 1 bit so that a zero parameter
  // still produces legal declarations.
  localparam int SW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int FW = (FLIGHT_TIMEOUT > 0) ? $clog2(FLIGHT_TIMEOUT + 1) : 1;

  localparam bit SETTLE_EN    = (SETTLE_CYCLES > 0);
  localparam bit FLIGHT_TO_EN = (FLIGHT_TIMEOUT > 0);
  localparam bit AIM_TO_EN    = (AIM_TIMEOUT > 0);

  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_EN ? SETTLE_CYCLES - 1 : 0);
  localparam logic [FW-1:0] FLIGHT_LAST = FW'(FLIGHT_TO_EN ? FLIGHT_TIMEOUT - 1 : 0);

  // Where a finished (or forfeited) turn goes. The SETTLE phase is skipped
  // entirely when SETTLE_CYCLES is 0.
  localparam state_t CAT_DONE = SETTLE_EN ? SETTLE_TO_DOG : DOG_AIM;
  localparam state_t DOG_DONE = SETTLE_EN ? SETTLE_TO_CAT : CAT_AIM;

  state_t          state_q, state_d;
  logic [SW-1:0]   settle_cnt_q, settle_cnt_d;
  logic [FW-1:0]   flight_cnt_q, flight_cnt_d;
  logic            seen_high_q, seen_high_d;
  logic            in_prev_q, in_prev_d;
  logic            fall;
  logic            flight_end;
  logic            aim_timeout_hit;

`ifdef TURN_TIMEOUT_EN
  localparam int AW = (AIM_TIMEOUT > 0) ? $clog2(AIM_TIMEOUT + 1) : 1;
  localparam logic [AW-1:0] AIM_LAST = AW'(AIM_TO_EN ? AIM_TIMEOUT - 1 : 0);

  logic [AW-1:0] aim_cnt_q, aim_cnt_d;

  // The counter runs only while the active player idles in AIM. It clears on
  // any exit from AIM, whether that exit is a throw or a forfeit.
  always_comb begin
    aim_cnt_d = '0;
    if (AIM_TO_EN && (state_q == CAT_AIM || state_q == DOG_AIM) &&
        !throw_flag && !aim_timeout_hit) begin
      aim_cnt_d = aim_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk60MHz) begin
    if (rst) begin
      aim_cnt_q <= '0;
    end else begin
      aim_cnt_q <= aim_cnt_d;
    end
  end

  assign aim_timeout_hit = (aim_cnt_q == AIM_LAST);
`else
  assign aim_timeout_hit = 1'b0;
`endif

  // A flight only ends on a full high-then-low pulse of in_throw_flag. A
  // falling edge that arrives before any high cycle is seen in FLIGHT is ignored.
  assign fall       = in_prev_q & ~in_throw_flag;
  assign flight_end = (seen_high_q & fall) |
                      (FLIGHT_TO_EN & (flight_cnt_q == FLIGHT_LAST));

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = '0;
    flight_cnt_d = '0;
    seen_high_d  = seen_high_q;
    in_prev_d    = in_throw_flag;

    case (state_q)
      CAT_AIM, DOG_AIM: begin
        // A throw beats a timeout that lands on the same cycle.
        if (throw_flag) begin
          state_d     = (state_q == CAT_AIM) ? CAT_FLIGHT : DOG_FLIGHT;
          seen_high_d = 1'b0;
        end else if (AIM_TO_EN && aim_timeout_hit) begin
          state_d = (state_q == CAT_AIM) ? CAT_DONE : DOG_DONE;
        end
      end

      CAT_FLIGHT, DOG_FLIGHT: begin
        if (in_throw_flag) begin
          seen_high_d = 1'b1;
        end
        if (flight_end) begin
          state_d = (state_q == CAT_FLIGHT) ? CAT_DONE : DOG_DONE;
        end else if (FLIGHT_TO_EN) begin
          flight_cnt_d = flight_cnt_q + 1'b1;
        end
      end

      SETTLE_TO_DOG, SETTLE_TO_CAT: begin
        if (settle_cnt_q == SETTLE_LAST) begin
          state_d = (state_q == SETTLE_TO_DOG) ? DOG_AIM : CAT_AIM;
        end else begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end

      // Codes 6/7 are unreachable in normal operation. Recover to CAT_AIM.
      default: begin
        state_d     = CAT_AIM;
        seen_high_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk60MHz) begin
    if (rst) begin
      state_q      <= CAT_AIM;
      settle_cnt_q <= '0;
      flight_cnt_q <= '0;
      seen_high_q  <= 1'b0;
      in_prev_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      flight_cnt_q <= flight_cnt_d;
      seen_high_q  <= seen_high_d;
      in_prev_q    <= in_prev_d;
    end
  end

  assign turn = state_q;

endmodule

// File: tb/tb_turn_manager.sv
// Directed testbench for turn_manager.
// The DUT is built with SETTLE_CYCLES=2, FLIGHT_TIMEOUT=16 and AIM_TIMEOUT=8.
// Inputs change just after a falling edge. turn is sampled on the next
// falling edge, so every check shows the effect of exactly one rising edge.

module tb_turn_manager;

  logic       clk = 1'b0;
  logic       rst;
  logic       throw_flag;
  logic       in_throw_flag;
  logic [2:0] turn;

  int checks = 0;
  int errors = 0;

  turn_manager #(
    .SETTLE_CYCLES (2),
    .FLIGHT_TIMEOUT(16),
    .AIM_TIMEOUT   (8)
  ) dut (
    .clk60MHz     (clk),
    .rst          (rst),
    .throw_flag   (throw_flag),
    .in_throw_flag(in_throw_flag),
    .turn         (turn)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic expect_turn(input string tag, input logic [2:0] exp);
    checks++;
    assert (turn === exp)
    else begin
      errors++;
      $error("FAIL %s: turn=%0d expected %0d", tag, turn, exp);
    end
  endtask

  task automatic step_chk(input string tag, input logic [2:0] exp);
    tick();
    expect_turn(tag, exp);
  endtask

  initial begin
    rst           = 1'b1;
    throw_flag    = 1'b0;
    in_throw_flag = 1'b0;
    tick();
    tick();
    expect_turn("reset_state", 3'd0);
    rst = 1'b0;

`ifndef TURN_TIMEOUT_EN
    // With no inputs active, CAT_AIM holds.
    for (int i = 0; i < 20; i++) step_chk("idle_hold", 3'd0);
`endif

    // CAT throw: FLIGHT one edge later. It stays in FLIGHT while the throw is held or dropped.
    throw_flag = 1'b1;
    step_chk("cat_aim_to_flight", 3'd1);
    for (int i = 0; i < 3; i++) step_chk("cat_throw_held", 3'd1);
    throw_flag = 1'b0;
    step_chk("cat_throw_dropped", 3'd1);

    // Projectile pulse: high for 4 cycles, then low.
    in_throw_flag = 1'b1;
    for (int i = 0; i < 4; i++) step_chk("cat_in_flight", 3'd1);
    in_throw_flag = 1'b0;
    step_chk("cat_fall_to_settle", 3'd4);
    step_chk("cat_settle_hold", 3'd4);
    step_chk("settle_to_dog_aim", 3'd2);

    // DOG turn. Throw pulses during FLIGHT have no effect.
    throw_flag = 1'b1;
    step_chk("dog_aim_to_flight", 3'd3);
    throw_flag = 1'b0;
    step_chk("dog_flight_hold", 3'd3);
    throw_flag = 1'b1;
    step_chk("dog_flight_ignores_throw", 3'd3);
    throw_flag    = 1'b0;
    in_throw_flag = 1'b1;
    step_chk("dog_in_flight_a", 3'd3);
    step_chk("dog_in_flight_b", 3'd3);
    in_throw_flag = 1'b0;
    throw_flag    = 1'b1;
    step_chk("dog_fall_to_settle", 3'd5);

    // In SETTLE both inputs are ignored. The throw is still high when
    // CAT_AIM begins, so it is accepted in the first AIM cycle.
    in_throw_flag = 1'b1;
    step_chk("settle_ignores_inputs", 3'd5);
    step_chk("settle_to_cat_aim", 3'd0);
    step_chk("held_throw_accepted", 3'd1);

    // in_throw_flag was high on entry and falls at once. No high cycle was
    // seen in FLIGHT, so that fall is ignored and the flight times out
    // after exactly 16 cycles.
    throw_flag    = 1'b0;
    in_throw_flag = 1'b0;
    for (int i = 0; i < 15; i++) step_chk("flight_wait_no_pulse", 3'd1);
    step_chk("flight_timeout", 3'd4);

    // Reset during SETTLE and during FLIGHT.
    rst = 1'b1;
    step_chk("rst_mid_settle", 3'd0);
    rst = 1'b0;
    step_chk("aim_after_settle_rst", 3'd0);
    throw_flag = 1'b1;
    step_chk("throw_after_rst", 3'd1);
    throw_flag    = 1'b0;
    in_throw_flag = 1'b1;
    rst           = 1'b1;
    step_chk("rst_mid_flight", 3'd0);
    rst           = 1'b0;
    in_throw_flag = 1'b0;
    step_chk("aim_after_flight_rst", 3'd0);

`ifdef TURN_TIMEOUT_EN
    // An idle CAT_AIM forfeits after 8 cycles: turn goes 4, then 2.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 7; i++) step_chk("cat_aim_wait", 3'd0);
    step_chk("aim_timeout_to_settle", 3'd4);
    step_chk("timeout_settle_hold", 3'd4);
    step_chk("timeout_to_dog_aim", 3'd2);
    // A throw on the 8th AIM cycle wins over the forfeit.
    for (int i = 0; i < 7; i++) step_chk("dog_aim_wait", 3'd2);
    throw_flag = 1'b1;
    step_chk("throw_beats_timeout", 3'd3);
    throw_flag = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
